// File: rtl/datamem_sweep_pkg.sv
// Shared types and default constants for the swept data memory.
package datamem_sweep_pkg;

  // Post-reset flow: clear every word, load two presets, then serve requests.
  typedef enum logic [1:0] {
    SWEEP = 2'd0,
    LOAD0 = 2'd1,
    LOAD1 = 2'd2,
    RUN   = 2'd3
  } state_e;

  localparam int         DEF_DW    = 8;
  localparam int         DEF_AW    = 8;
  localparam logic [7:0] DEF_INIT0 = 8'hCA;
  localparam logic [7:0] DEF_INIT1 = 8'h00;
  localparam bit         DEF_WT    = 1'b0;

endpackage

// File: rtl/datamem_array.sv
// DW x 2**AW storage: synchronous write, combinational read.
// The owner registers the read data, so an access still costs one cycle.
module datamem_array #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  // Array is never reset; the clear engine in the top owns initialisation.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  assign dout = mem[addr];

endmodule

// File: rtl/datamem_sweep.sv
// Parametrised data memory with a post-reset clear engine and a
// request/valid handshake. Ready stays low until the sweep and the two
// preset loads are done; requests seen before that are dropped.
module datamem_sweep
  import datamem_sweep_pkg::*;
#(
  parameter int            DW            = DEF_DW,
  parameter int            AW            = DEF_AW,
  parameter logic [DW-1:0] INIT_FILL     = '0,
  parameter logic [7:0]    INIT0         = DEF_INIT0,
  parameter logic [7:0]    INIT1         = DEF_INIT1,
  parameter bit            WRITE_THROUGH = DEF_WT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Req,
  input  logic          MemWrite,
  input  logic [AW-1:0] DataAddr,
  input  logic [DW-1:0] DataIn,
  output logic [DW-1:0] DataOut,
  output logic          RdValid,
  output logic          Ready
);

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic [DW-1:0] dout_q;
  logic          rdv_q;
  logic          rdy_q;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  // Write-port mux: the clear engine owns the array until RUN. In RUN the
  // write enable is gated by Req so junk on MemWrite/DataAddr is harmless.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = DataAddr;
    ram_din  = DataIn;
    case (state_q)
      SWEEP: begin
        ram_we   = 1'b1;
        ram_addr = cnt_q;
        ram_din  = INIT_FILL;
      end
      LOAD0: begin
        ram_we   = 1'b1;
        ram_addr = '0;
        ram_din  = DW'(INIT0);
      end
      LOAD1: begin
        ram_we   = 1'b1;
        ram_addr = AW'(1);
        ram_din  = DW'(INIT1);
      end
      RUN:     ram_we = Req & MemWrite;
      default: ram_we = 1'b0;
    endcase
  end

  datamem_array #(.DW(DW), .AW(AW)) u_array (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  // Control FSM with registered DataOut/RdValid/Ready. The sweep ends on
  // the all-ones address, before the counter wraps back to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
      dout_q  <= '0;
      rdv_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      rdv_q <= 1'b0;
      case (state_q)
        SWEEP: begin
          cnt_q <= cnt_q + 1'b1;
          if (&cnt_q) state_q <= LOAD0;
        end
        LOAD0: state_q <= LOAD1;
        LOAD1: begin
          state_q <= RUN;
          rdy_q   <= 1'b1;
        end
        RUN: begin
          if (Req && !MemWrite) begin
            dout_q <= ram_dout;
            rdv_q  <= 1'b1;
          end else if (Req && MemWrite && WRITE_THROUGH) begin
            dout_q <= DataIn;
            rdv_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= SWEEP;
          cnt_q   <= '0;
          rdy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign DataOut = dout_q;
  assign RdValid = rdv_q;
  assign Ready   = rdy_q;

endmodule

// File: tb/tb_datamem_sweep.sv
// Directed bench for datamem_sweep: three instances cover the small
// write-hold config, write-through, and a wide/deep config with a fill value.
module tb_datamem_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;
  int n;
  logic sawv;

  // Instance A: AW=4, write-hold
  logic       rst_a = 1'b1, req_a = 1'b0, we_a = 1'b0;
  logic [3:0] addr_a = '0;
  logic [7:0] din_a = '0, dout_a;
  logic       vld_a, rdy_a;

  // Instance B: AW=4, write-through
  logic       rst_b = 1'b1, req_b = 1'b0, we_b = 1'b0;
  logic [3:0] addr_b = '0;
  logic [7:0] din_b = '0, dout_b;
  logic       vld_b, rdy_b;

  // Instance C: DW=16, AW=6, fill 0xBEEF
  logic        rst_c = 1'b1, req_c = 1'b0, we_c = 1'b0;
  logic [5:0]  addr_c = '0;
  logic [15:0] din_c = '0, dout_c;
  logic        vld_c, rdy_c;

  datamem_sweep #(.DW(8), .AW(4)) dut_a (
    .clk(clk), .reset(rst_a), .Req(req_a), .MemWrite(we_a), .DataAddr(addr_a),
    .DataIn(din_a), .DataOut(dout_a), .RdValid(vld_a), .Ready(rdy_a));

  datamem_sweep #(.DW(8), .AW(4), .WRITE_THROUGH(1'b1)) dut_b (
    .clk(clk), .reset(rst_b), .Req(req_b), .MemWrite(we_b), .DataAddr(addr_b),
    .DataIn(din_b), .DataOut(dout_b), .RdValid(vld_b), .Ready(rdy_b));

  datamem_sweep #(.DW(16), .AW(6), .INIT_FILL(16'hBEEF)) dut_c (
    .clk(clk), .reset(rst_c), .Req(req_c), .MemWrite(we_c), .DataAddr(addr_c),
    .DataIn(din_c), .DataOut(dout_c), .RdValid(vld_c), .Ready(rdy_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("a_rst_rdy", rdy_a, 0);
    chk("a_rst_vld", vld_a, 0);
    chk("a_rst_dout", dout_a, 0);
    chk("c_rst_dout", dout_c, 0);

    // Write attempt during the sweep must be dropped
    req_a = 1'b1; we_a = 1'b1; addr_a = 4'd5; din_a = 8'hFF;
    #1;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    n = 0; sawv = 1'b0;
    do begin
      step(); n++;
      if (vld_a) sawv = 1'b1;
    end while (!rdy_a && n < 100);
    chk("a_rdy_lat", n, 18);
    chk("a_vld_in_sweep", sawv, 0);

    // Back-to-back reads of every word
    we_a = 1'b0; addr_a = 4'd0;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("a_rd%0d", i - 1), dout_a, (i == 1) ? 32'hCA : 32'h0);
      chk($sformatf("a_rdv%0d", i - 1), vld_a, 1);
      if (i < 16) addr_a = 4'(i);
      else req_a = 1'b0;
    end
    step();
    chk("a_idle_vld", vld_a, 0);
    chk("a_idle_hold", dout_a, 0);

    // Read 0, write 7 (DataOut must hold), read 7 back
    req_a = 1'b1; we_a = 1'b0; addr_a = 4'd0;
    step();
    chk("a_rd0_again", dout_a, 8'hCA);
    we_a = 1'b1; addr_a = 4'd7; din_a = 8'h5A;
    step();
    chk("a_wr_vld", vld_a, 0);
    chk("a_wr_hold", dout_a, 8'hCA);
    we_a = 1'b0;
    step();
    chk("a_raw7", dout_a, 8'h5A);
    chk("a_raw7_vld", vld_a, 1);

    // Write 9, confirm, then reset mid-cycle
    we_a = 1'b1; addr_a = 4'd9; din_a = 8'h11;
    step();
    we_a = 1'b0;
    step();
    chk("a_rd9_pre", dout_a, 8'h11);
    req_a = 1'b0;
    #3 rst_a = 1'b1;
    #1;
    chk("a_rst_async_rdy", rdy_a, 0);
    chk("a_rst_async_dout", dout_a, 0);
    #2 rst_a = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst_a = 1'b1;
    #1;
    chk("a_rst_mid_rdy", rdy_a, 0);
    #2 rst_a = 1'b0;
    n = 0;
    do begin
      step(); n++;
    end while (!rdy_a && n < 100);
    chk("a_rdy_lat2", n, 18);
    req_a = 1'b1; we_a = 1'b0; addr_a = 4'd9;
    step();
    chk("a_rd9_cleared", dout_a, 0);
    chk("a_rd9_vld", vld_a, 1);
    req_a = 1'b0;

    // Write-through instance
    chk("b_rdy", rdy_b, 1);
    req_b = 1'b1; we_b = 1'b1; addr_b = 4'd3; din_b = 8'h3C;
    step();
    chk("b_wt_dout", dout_b, 8'h3C);
    chk("b_wt_vld", vld_b, 1);
    we_b = 1'b0;
    step();
    chk("b_rd3", dout_b, 8'h3C);
    chk("b_rd3_vld", vld_b, 1);
    req_b = 1'b0;
    step();
    chk("b_idle_vld", vld_b, 0);

    // Wide/deep instance
    chk("c_rdy", rdy_c, 1);
    req_c = 1'b1; we_c = 1'b0; addr_c = 6'd63;
    step();
    chk("c_rd63", dout_c, 16'hBEEF);
    addr_c = 6'd0;
    step();
    chk("c_rd0", dout_c, 16'h00CA);
    addr_c = 6'd1;
    step();
    chk("c_rd1", dout_c, 16'h0000);
    req_c = 1'b0;
    #2 rst_c = 1'b1;
    #2 rst_c = 1'b0;
    n = 0;
    do begin
      step(); n++;
    end while (!rdy_c && n < 200);
    chk("c_rdy_lat", n, 66);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/datamem_sweep.md
Name: datamem_sweep

Overview:
- Parametrised data memory, successor to the fixed 8-bit x 256 data memory.
- Single clocked port with registered read data and an explicit request/valid handshake.
- After every reset, a hardware clear engine writes INIT_FILL to every word, then loads two preset words.
- Sits between the core's load/store path and its data storage.

Parameters:
- DW, 8, data word width in bits.
- AW, 8, address width; DEPTH = 2**AW words.
- INIT_FILL, 0, value written to every word during the post-reset sweep.
- INIT0, 8'hCA, value loaded into word 0 at the end of the sweep (zero-extended or truncated to DW).
- INIT1, 8'h00, value loaded into word 1 at the end of the sweep (zero-extended or truncated to DW).
- WRITE_THROUGH, 0. 1 = a write also drives DataOut with DataIn and pulses RdValid; 0 = DataOut holds on a write.

Ports:
- clk  in  1  clock, all state changes on the rising edge.
- reset  in  1  asynchronous active-high reset.
- Req  in  1  access request, sampled only while Ready=1.
- MemWrite  in  1  1 = write, 0 = read; meaningful only with Req.
- DataAddr  in  AW  word address.
- DataIn  in  DW  write data.
- DataOut  out  DW  registered read data.
- RdValid  out  1  one-cycle pulse; DataOut was updated by the previous accepted access.
- Ready  out  1  1 = block accepts requests; 0 during the init sweep.

Behaviour:
- Reset is asynchronous, active-high, and applies to control registers only; the array is never reset combinationally.
- Reset values: DataOut=0, RdValid=0, Ready=0, FSM=SWEEP, sweep counter=0.
- FSM states: SWEEP, LOAD0, LOAD1, RUN.
- SWEEP: each cycle write INIT_FILL to dm[cnt], then cnt++. When cnt==DEPTH-1 is written, go to LOAD0.
- SWEEP takes DEPTH cycles; the counter is AW bits wide, and the terminal count is detected before wrap.
- LOAD0: write INIT0 to dm[0], go to LOAD1.
- LOAD1: write INIT1 to dm[1], go to RUN.
- Ready rises on the first cycle in RUN. Total reset-release-to-Ready is DEPTH+2 cycles.
- RUN: on a clock edge with Req=1 and MemWrite=0, DataOut <= dm[DataAddr] and RdValid=1 on the next cycle. Read latency is 1 cycle.
- RUN: on a clock edge with Req=1 and MemWrite=1, dm[DataAddr] <= DataIn.
  - WRITE_THROUGH=0: DataOut holds and RdValid=0.
  - WRITE_THROUGH=1: DataOut <= DataIn and RdValid=1.
- Req=0 in RUN: no array access, DataOut holds, RdValid=0.
- Req while Ready=0 is ignored: no write, no read, RdValid stays 0, and nothing is queued.
- Back-to-back reads: one per cycle with no bubbles; RdValid stays high continuously.
- Read of an address written on the previous cycle returns the new data.
- reset asserted mid-sweep or mid-RUN: control returns to SWEEP immediately, and the sweep restarts from address 0. Array contents are undefined until the new sweep completes.
- X on DataAddr/MemWrite while Req=0 must not corrupt the array.

Decomposition:
- Shared package: FSM state enum (SWEEP, LOAD0, LOAD1, RUN) and the default-parameter constants.
- One natural sub-module, datamem_array: a plain DW x DEPTH synchronous single-port RAM with we/addr/din/dout.
- The top level owns the FSM, the sweep counter, the write-port muxing between sweep and user, and the RdValid/write-through logic.

Test Plan:
- Release reset with AW=4 (DEPTH=16) -> Ready=0 for exactly 18 cycles, then 1. Reads of addresses 0..15 return 0xCA, 0x00, then 0x00 x14; each RdValid arrives 1 cycle after its Req.
- Write 0x5A to address 7, then read 7 on the next cycle -> DataOut=0x5A with RdValid=1 one cycle after the read request. With WRITE_THROUGH=0, RdValid=0 during the write-response cycle.
- WRITE_THROUGH=1: write 0x3C to address 3 -> next cycle DataOut=0x3C and RdValid=1; a subsequent read of 3 also returns 0x3C.
- Assert Req with MemWrite=1, address 5, data 0xFF during the sweep -> ignored; after Ready, address 5 reads 0x00.
- Write 0x11 to address 9, wait until Ready, then pulse reset asynchronously mid-cycle while a sweep is half done -> Ready drops the same cycle, then rises 18 cycles after release; address 9 reads 0x00.
- DW=16, AW=6, INIT_FILL=0xBEEF -> after 66 cycles, address 63 reads 0xBEEF, address 0 reads 0x00CA, address 1 reads 0x0000.
